dmem_responder: RTL and testbench

Data-memory responder for the 8-bit datapath: it serves the core's load/store requests on a registered request/acknowledge handshake with a fixed, parameterised number of wait states. The byte-addressed storage array sits behind a small state machine that latches each request, counts the wait states, performs the access and returns a one-cycle acknowledge. It is the memory end of the core's data port: the ALU result is the address, the register operand is the write data, and `rdata` feeds the load result mux.

---
 rtl/dmem_pkg.sv | 8 +
 rtl/dmem_responder_if.sv | 22 ++
 rtl/dmem_array.sv | 38 +++
 rtl/dmem_responder.sv | 84 ++++++++
 tb/tb_dmem_responder.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding, wait-counter width and parity helper for the data-memory responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int WAIT_W = 4;
  function automatic logic par(input logic [7:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: core-side request/acknowledge data port; inject_perr exists only with DMEM_PARITY_EN
interface dmem_responder_if;
  logic req, we, ack, busy, err;
  logic [7:0] addr, wdata, rdata;
`ifdef DMEM_PARITY_EN
  logic inject_perr;
`endif
  modport slave (
    input req, we, addr, wdata,
`ifdef DMEM_PARITY_EN
    inject_perr,
`endif
    output ack, rdata, busy, err
  );
  modport master (
    output req, we, addr, wdata,
`ifdef DMEM_PARITY_EN
    inject_perr,
`endif
    input ack, rdata, busy, err
  );
endinterface

// File: rtl/dmem_array.sv
// dmem_array: DEPTH-byte sync-write / registered-read store; DMEM_PARITY_EN adds a parity bit and sticky err
module dmem_array import dmem_pkg::*; #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [7:0]               wdata,
`ifdef DMEM_PARITY_EN
  input  logic                     inj,
`endif
  output logic [7:0]               rdata,
  output logic                     err
);
`ifdef DMEM_PARITY_EN
  logic [8:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (en && we) mem[addr] <= {par(wdata) ^ inj, wdata};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rdata <= '0;
      err   <= 1'b0;
    end else if (en && !we) begin
      rdata <= mem[addr][7:0];
      err   <= err | (par(mem[addr][7:0]) != mem[addr][8]);
    end
`else
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (en && we) mem[addr] <= wdata;
  always_ff @(posedge clk or posedge reset)
    if (reset) rdata <= '0;
    else if (en && !we) rdata <= mem[addr];
  assign err = 1'b0;
`endif
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated load/store responder for the core data port (optional DMEM_PARITY_EN)
module dmem_responder import dmem_pkg::*; #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input logic            clk,
  input logic            reset,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [WAIT_W-1:0] WC = WAIT_W'(WAIT_CYCLES);
  state_t state, state_n;
  logic [WAIT_W-1:0] cnt, cnt_n;
  logic r_we, idle, go, a_we, a_inj, r_inj;
  logic [AW-1:0] r_addr, a_addr;
  logic [7:0] r_wdata, a_wd;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: if (bus.req) begin
        state_n = WC == '0 ? RESP : WAIT;
        cnt_n   = WC;
      end
      WAIT: begin
        cnt_n   = cnt - 1'b1;
        state_n = cnt <= 1 ? RESP : WAIT;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_inj   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (idle && bus.req) begin
        r_we    <= bus.we;
        r_addr  <= bus.addr[AW-1:0];
        r_wdata <= bus.wdata;
`ifdef DMEM_PARITY_EN
        r_inj   <= bus.inject_perr;
`else
        r_inj   <= 1'b0;
`endif
      end
    end
  // with zero wait states the access commits on the sampling edge, so bypass the request latches
  assign idle   = state == IDLE;
  assign go     = state_n == RESP && !reset;
  assign a_we   = idle ? bus.we : r_we;
  assign a_addr = idle ? bus.addr[AW-1:0] : r_addr;
  assign a_wd   = idle ? bus.wdata : r_wdata;
`ifdef DMEM_PARITY_EN
  assign a_inj  = idle ? bus.inject_perr : r_inj;
`else
  assign a_inj  = r_inj;
`endif
  assign bus.ack  = state == RESP;
  assign bus.busy = !idle;
  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .reset (reset),
    .en    (go),
    .we    (a_we),
    .addr  (a_addr),
    .wdata (a_wd),
`ifdef DMEM_PARITY_EN
    .inj   (a_inj),
`endif
    .rdata (bus.rdata),
    .err   (bus.err)
  );
`ifndef DMEM_PARITY_EN
  logic unused_inj;
  assign unused_inj = a_inj;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of three responder configurations (W=2, W=0, DEPTH=64)
module tb_dmem_responder;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  dmem_responder_if i0 (), i1 (), i2 ();
  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) u0 (.clk(clk), .reset(reset), .bus(i0));
  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) u1 (.clk(clk), .reset(reset), .bus(i1));
  dmem_responder #(.DEPTH(64),  .WAIT_CYCLES(2)) u2 (.clk(clk), .reset(reset), .bus(i2));
  logic req_v [3], we_v [3], inj_v [3], ack_o [3], busy_o [3], err_o [3];
  logic [7:0] addr_v [3], wd_v [3], rd_o [3];
  assign {i0.req, i0.we, i0.addr, i0.wdata} = {req_v[0], we_v[0], addr_v[0], wd_v[0]};
  assign {i1.req, i1.we, i1.addr, i1.wdata} = {req_v[1], we_v[1], addr_v[1], wd_v[1]};
  assign {i2.req, i2.we, i2.addr, i2.wdata} = {req_v[2], we_v[2], addr_v[2], wd_v[2]};
  assign {ack_o[0], busy_o[0], err_o[0], rd_o[0]} = {i0.ack, i0.busy, i0.err, i0.rdata};
  assign {ack_o[1], busy_o[1], err_o[1], rd_o[1]} = {i1.ack, i1.busy, i1.err, i1.rdata};
  assign {ack_o[2], busy_o[2], err_o[2], rd_o[2]} = {i2.ack, i2.busy, i2.err, i2.rdata};
`ifdef DMEM_PARITY_EN
  assign i0.inject_perr = inj_v[0];
  assign i1.inject_perr = inj_v[1];
  assign i2.inject_perr = inj_v[2];
`endif
  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic xfer(input int d, input logic w, input logic [7:0] a, input logic [7:0] wd,
                      input logic inj, output logic [7:0] rd, output int lat);
    @(negedge clk);
    req_v[d] = 1'b1; we_v[d] = w; addr_v[d] = a; wd_v[d] = wd; inj_v[d] = inj;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ack_o[d] && lat < 40);
    rd = rd_o[d];
    req_v[d] = 1'b0; we_v[d] = 1'b0; inj_v[d] = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    logic [7:0] rd;
    logic [7:0] ba [3];
    logic [7:0] bv [3];
    int lat, n_ack;
    ba = '{8'h00, 8'h7F, 8'hFF};
    bv = '{8'h11, 8'h22, 8'h33};
    for (int d = 0; d < 3; d++) begin
      req_v[d] = 0; we_v[d] = 0; inj_v[d] = 0; addr_v[d] = 0; wd_v[d] = 0;
    end
    @(negedge clk);
    chk("rst_ack", ack_o[0], 0);
    chk("rst_busy", busy_o[0], 0);
    chk("rst_rdata", rd_o[0], 0);
    chk("rst_err", err_o[0], 0);
    chk("rst_busy_w0", busy_o[1], 0);
    reset = 1'b0;
    xfer(0, 1, 8'h03, 8'hA5, 0, rd, lat);
    chk("w2_st_lat", lat, 3);
    xfer(0, 0, 8'h03, 8'h00, 0, rd, lat);
    chk("w2_ld_lat", lat, 3);
    chk("w2_ld_data", rd, 8'hA5);
    xfer(0, 1, 8'h80, 8'hFF, 0, rd, lat);
    chk("w2_st_keeps_rdata", rd, 8'hA5);
    xfer(0, 0, 8'h80, 8'h00, 0, rd, lat);
    chk("w2_ld_80", rd, 8'hFF);
    xfer(0, 1, 8'h10, 8'h00, 0, rd, lat);
    @(negedge clk);
    req_v[0] = 1; we_v[0] = 1; addr_v[0] = 8'h10; wd_v[0] = 8'h5A;
    @(negedge clk);
    chk("mid_busy", busy_o[0], 1);
    req_v[0] = 0; we_v[0] = 0;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy_o[0], 0);
    chk("mid_rst_ack", ack_o[0], 0);
    chk("mid_rst_rdata", rd_o[0], 0);
    @(negedge clk);
    reset = 1'b0;
    xfer(0, 0, 8'h10, 8'h00, 0, rd, lat);
    chk("abandoned_store", rd, 8'h00);
    @(negedge clk);
    req_v[0] = 1; we_v[0] = 1; addr_v[0] = 8'h20; wd_v[0] = 8'h3C;
    n_ack = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack_o[0]) n_ack++;
      if (i == 0) req_v[0] = 0;
      if (i == 1) begin req_v[0] = 1; addr_v[0] = 8'h21; wd_v[0] = 8'hEE; end
      if (i == 2) begin req_v[0] = 0; we_v[0] = 0; end
    end
    chk("pulse_one_ack", n_ack, 1);
    xfer(0, 0, 8'h20, 8'h00, 0, rd, lat);
    chk("pulse_data", rd, 8'h3C);
    for (int k = 0; k < 3; k++) begin
      xfer(1, 1, ba[k], bv[k], 0, rd, lat);
      chk("w0_st_lat", lat, 1);
    end
    @(negedge clk);
    req_v[1] = 1; we_v[1] = 0; addr_v[1] = ba[0];
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i % 2 == 0) begin
        chk("b2b_ack", ack_o[1], 1);
        chk("b2b_busy", busy_o[1], 1);
        chk("b2b_data", rd_o[1], bv[i/2]);
        if (i < 4) addr_v[1] = ba[i/2+1];
      end else begin
        chk("b2b_ack_gap", ack_o[1], 0);
        chk("b2b_busy_gap", busy_o[1], 0);
      end
      if (i == 5) req_v[1] = 0;
    end
    xfer(2, 1, 8'h41, 8'h77, 0, rd, lat);
    xfer(2, 0, 8'h01, 8'h00, 0, rd, lat);
    chk("wrap_01", rd, 8'h77);
    xfer(2, 1, 8'h3F, 8'h99, 0, rd, lat);
    xfer(2, 0, 8'hFF, 8'h00, 0, rd, lat);
    chk("wrap_ff", rd, 8'h99);
`ifdef DMEM_PARITY_EN
    xfer(0, 1, 8'h05, 8'h0F, 1, rd, lat);
    chk("perr_before_load", err_o[0], 0);
    xfer(0, 0, 8'h05, 8'h00, 0, rd, lat);
    chk("perr_data", rd, 8'h0F);
    chk("perr_err_at_ack", err_o[0], 1);
    xfer(0, 0, 8'h03, 8'h00, 0, rd, lat);
    chk("perr_sticky", err_o[0], 1);
    chk("perr_clean_data", rd, 8'hA5);
    reset = 1'b1;
    #1;
    chk("perr_reset_clears", err_o[0], 0);
    @(negedge clk);
    reset = 1'b0;
`else
    chk("err_tied0", err_o[0], 0);
    chk("err_tied0_w0", err_o[1], 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
